// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_SLT  = 3'd3,
        OP_SLL  = 3'd4,
        OP_SRL  = 3'd5,
        OP_SRA  = 3'd6,
        OP_RSVD = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags for every opcode.
// OP_RSVD reports illegal with z=0; the pipe decides whether that code means MUL.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             equal,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;

    assign shamt = y[SHAMT_W-1:0];
    assign sum   = x + y;
    assign diff  = x - y;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        z        = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_AND: z = x & y;
            OP_ADD: begin
                z        = sum;
                overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                z        = diff;
                overflow = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SLT: z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLL: z = x << shamt;
            OP_SRL: z = x >> shamt;
            OP_SRA: z = $signed(x) >>> shamt;
            default: illegal = 1'b1;
        endcase
    end

    assign equal = (x == y);
    assign zero  = (z == '0);

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; one op in flight at a time.
// Define ALU_MUL_EN to turn the reserved opcode into an iterative shift-add multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_e          in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_equal,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_z_q, out_z_d;
    logic             out_equal_q, out_equal_d;
    logic             out_overflow_q, out_overflow_d;
    logic             out_zero_q, out_zero_d;
    logic             out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    logic [WIDTH-1:0] core_z;
    logic             core_equal, core_overflow, core_zero, core_illegal;
    logic             accept, take_core;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (in_op),
        .x        (in_x),
        .y        (in_y),
        .z        (core_z),
        .equal    (core_equal),
        .overflow (core_overflow),
        .zero     (core_zero),
        .illegal  (core_illegal)
    );

    assign in_ready = rst_n & (state_q == ST_IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

`ifdef ALU_MUL_EN
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W:0] ITER_DONE = (SHAMT_W + 1)'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHAMT_W:0]   iter_q, iter_d;
    logic               mul_eq_q, mul_eq_d;
    logic               start_mul;

    assign start_mul = accept & (in_op == OP_RSVD);
    assign take_core = accept & ~start_mul;
`else
    assign take_core = accept;
`endif

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_z_d        = out_z_q;
        out_equal_d    = out_equal_q;
        out_overflow_d = out_overflow_q;
        out_zero_d     = out_zero_q;
        out_illegal_d  = out_illegal_q;
        illegal_cnt_d  = illegal_cnt_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        mul_eq_d = mul_eq_q;
`endif

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        // A new op overrides the drop above, giving back-to-back issue.
        if (take_core) begin
            out_valid_d    = 1'b1;
            out_z_d        = core_z;
            out_equal_d    = core_equal;
            out_overflow_d = core_overflow;
            out_zero_d     = core_zero;
            out_illegal_d  = core_illegal;
            if (core_illegal && !(&illegal_cnt_q)) illegal_cnt_d = illegal_cnt_q + 1'b1;
        end

`ifdef ALU_MUL_EN
        if (start_mul) begin
            state_d  = ST_MUL;
            mcand_d  = {{WIDTH{1'b0}}, in_x};
            mplier_d = in_y;
            acc_d    = '0;
            iter_d   = '0;
            mul_eq_d = core_equal;
        end

        if (state_q == ST_MUL) begin
            if (iter_q != ITER_DONE) begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + 1'b1;
            end else begin
                state_d        = ST_IDLE;
                out_valid_d    = 1'b1;
                out_z_d        = acc_q[WIDTH-1:0];
                out_equal_d    = mul_eq_q;
                out_overflow_d = |acc_q[2*WIDTH-1:WIDTH];
                out_zero_d     = (acc_q[WIDTH-1:0] == '0);
                out_illegal_d  = 1'b0;
            end
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            out_valid_q    <= 1'b0;
            out_z_q        <= '0;
            out_equal_q    <= 1'b0;
            out_overflow_q <= 1'b0;
            out_zero_q     <= 1'b0;
            out_illegal_q  <= 1'b0;
            illegal_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_z_q        <= out_z_d;
            out_equal_q    <= out_equal_d;
            out_overflow_q <= out_overflow_d;
            out_zero_q     <= out_zero_d;
            out_illegal_q  <= out_illegal_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

`ifdef ALU_MUL_EN
    // NOTE: multiplier datapath is not reset; it is fully loaded on start and only read in ST_MUL.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
        iter_q   <= iter_d;
        mul_eq_q <= mul_eq_d;
    end
`endif

    assign out_valid    = out_valid_q;
    assign out_z        = out_z_q;
    assign out_equal    = out_equal_q;
    assign out_overflow = out_overflow_q;
    assign out_zero     = out_zero_q;
    assign out_illegal  = out_illegal_q;
    assign illegal_cnt  = illegal_cnt_q;

endmodule
